pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, width of every address port.
REQ-002 Parameter RESET_VEC, default 32'h0000_8000, value loaded into pc by reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0100, target taken on trap.
REQ-004 Parameter INC, default 4, sequential increment; power of two, at least 4.
REQ-005 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, at least 2.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 stall  in  1  hold pc; ignored when trap or redirect is asserted.
REQ-009 redirect  in  1  take redirect_target (branch/jump from ALU).
REQ-010 redirect_target  in  XLEN  redirect destination.
REQ-011 trap  in  1  take TRAP_VEC.
REQ-012 call  in  1  push pc+INC onto RAS when pc advances.
REQ-013 ret  in  1  pop RAS top as next pc when pc advances.
REQ-014 pc  out  XLEN  registered current fetch address.
REQ-015 pc_nxt  out  XLEN  combinational value pc takes at next edge.
REQ-016 pc_valid  out  1  pc is a fetchable address this cycle.
REQ-017 ras_empty / ras_full  out  1 each  RAS occupancy flags.
REQ-018 misalign_err  out  1  one-cycle pulse: redirect_target not INC-aligned.
REQ-019 ras_underflow  out  1  one-cycle pulse: ret with empty RAS.

Function
REQ-020 Next-pc priority SHALL be: trap > redirect > ret (RAS non-empty) > stall (hold) > pc+INC.
REQ-021 pc_nxt SHALL equal the selected value in the same cycle; pc SHALL take it at the next rising edge (one-cycle latency).
REQ-022 pc+INC arithmetic SHALL be modulo 2^XLEN; XLEN'hFFFF_FFFC+4 wraps to 0.
REQ-023 redirect_target SHALL have its low log2(INC) bits forced to zero; misalign_err SHALL pulse for one cycle, registered, when any of those bits were set.
REQ-024 FSM states SHALL be HOLD, RUN and FLUSH.
REQ-025 HOLD is entered on reset; it lasts one cycle after reset release with pc_valid=0, then moves to RUN.
REQ-026 In RUN, trap or redirect SHALL move to FLUSH; otherwise the FSM stays in RUN.
REQ-027 FLUSH SHALL last one cycle with pc_valid=0, then return to RUN unless a new trap or redirect occurs, which re-enters FLUSH.
REQ-028 pc_valid SHALL be 1 only in RUN; stall does not clear pc_valid.
REQ-029 The RAS SHALL be a circular buffer with a pointer and a count; pushes and pops act only when pc advances (no stall) and no trap or redirect is present.
REQ-030 A push on a full RAS SHALL overwrite the oldest entry; count stays at RAS_DEPTH.
REQ-031 A ret with an empty RAS SHALL select pc+INC and pulse ras_underflow for one cycle.
REQ-032 call and ret in the same cycle SHALL pop the top as next pc, then push pc+INC in its place; count is unchanged.
REQ-033 A trap SHALL leave RAS contents unchanged.

Reset
REQ-034 On rst low: pc=RESET_VEC, FSM=HOLD, RAS count=0, pointer=0, pc_valid=0, ras_empty=1, ras_full=0, misalign_err=0, ras_underflow=0.
REQ-035 rst asserted mid-operation SHALL abort a FLUSH and discard RAS contents immediately, without waiting for a clock.
REQ-036 RAS data storage need not be reset.

Structure
REQ-037 FSM state encoding and the default RESET_VEC and TRAP_VEC values SHALL live in shared package pc_pkg.
REQ-038 The RAS SHALL be a sub-module named pc_ras, parametrised by XLEN and RAS_DEPTH.

Verification
REQ-039 Reset release at t=22 -> pc=0x8000 with pc_valid=0 for one cycle; then pc=0x8004, 0x8008 on successive cycles.
REQ-040 redirect=1 with target 0x1002 while stall=1 -> pc=0x1000, misalign_err pulses, pc_valid=0 one cycle, then 0x1004.
REQ-041 Five calls at pc 0x8000..0x8010 with RAS_DEPTH=4 -> ras_full=1; four rets return 0x8014, 0x8010, 0x800C, 0x8008; a fifth ret -> pc+4 and ras_underflow pulses.
REQ-042 trap and redirect in the same cycle -> pc=0x100; RAS count unchanged.
REQ-043 pc=0xFFFF_FFFC with no stall -> pc=0x0000_0000 at next edge.
REQ-044 rst asserted during FLUSH between clock edges -> pc=0x8000 and ras_empty=1 before the next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared FSM encoding and default vectors for the program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_8000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: the pointer marks the top entry, and the count saturates at RAS_DEPTH.
// When the stack is full, a push overwrites the oldest entry.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem_r [RAS_DEPTH];
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   wr_ptr_s;
  logic [CW-1:0]   cnt_r;
  logic            pop_s;

  assign top   = mem_r[ptr_r];
  assign empty = (cnt_r == CW'(0));
  assign full  = (cnt_r == CW'(RAS_DEPTH));
  assign pop_s = pop && !empty;

  // A simultaneous push and pop replaces the top entry in place.
  always_comb begin
    if (push && !pop_s) begin
      wr_ptr_s = ptr_r + PW'(1);
    end else begin
      wr_ptr_s = ptr_r;
    end
  end

  // Pointer and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= {PW{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (push && !pop_s) begin
      ptr_r <= ptr_r + PW'(1);
      if (!full) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else if (pop_s && !push) begin
      ptr_r <= ptr_r - PW'(1);
      cnt_r <= cnt_r - CW'(1);
    end
  end

  // Entry storage; contents are meaningless while the count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_s] <= push_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with trap, redirect and return-stack prediction.
// It also contains the HOLD/RUN/FLUSH validity FSM.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_nxt,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misalign_err,
  output logic            ras_underflow
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

  pc_state_e       state_r;
  pc_state_e       state_nxt_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_inc_s;
  logic [XLEN-1:0] pc_nxt_s;
  logic [XLEN-1:0] tgt_s;
  logic [XLEN-1:0] ras_top_s;
  logic            flush_s;
  logic            adv_s;
  logic            ret_hit_s;
  logic            push_s;
  logic            underflow_s;
  logic            misalign_s;
  logic            pc_valid_r;
  logic            misalign_r;
  logic            underflow_r;

  assign pc_inc_s    = pc_r + XLEN'(INC);
  assign tgt_s       = redirect_target & ~ALIGN_MASK;
  assign flush_s     = trap || redirect;
  assign adv_s       = !stall && !flush_s;
  assign ret_hit_s   = ret && adv_s && !ras_empty;
  assign push_s      = call && adv_s;
  assign underflow_s = ret && adv_s && ras_empty;
  // Misalignment matters only when the redirect actually wins over a trap.
  assign misalign_s  = redirect && !trap && ((redirect_target & ALIGN_MASK) != {XLEN{1'b0}});

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (ret_hit_s),
    .push_data (pc_inc_s),
    .top       (ras_top_s),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Next-pc selection in priority order.
  always_comb begin
    if (trap) begin
      pc_nxt_s = TRAP_VEC;
    end else if (redirect) begin
      pc_nxt_s = tgt_s;
    end else if (ret_hit_s) begin
      pc_nxt_s = ras_top_s;
    end else if (stall) begin
      pc_nxt_s = pc_r;
    end else begin
      pc_nxt_s = pc_inc_s;
    end
  end

  // FSM next state.
  always_comb begin
    case (state_r)
      HOLD:    state_nxt_s = RUN;
      RUN:     state_nxt_s = flush_s ? FLUSH : RUN;
      FLUSH:   state_nxt_s = flush_s ? FLUSH : RUN;
      default: state_nxt_s = HOLD;
    endcase
  end

  // State, pc and registered status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= HOLD;
      pc_r        <= RESET_VEC;
      pc_valid_r  <= 1'b0;
      misalign_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      pc_valid_r  <= (state_nxt_s == RUN);
      misalign_r  <= misalign_s;
      underflow_r <= underflow_s;
    end
  end

  assign pc            = pc_r;
  assign pc_nxt        = pc_nxt_s;
  assign pc_valid      = pc_valid_r;
  assign misalign_err  = misalign_r;
  assign ras_underflow = underflow_r;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, hand-written corner sequences,
// and randomized cycles against a queue-based reference model.
module tb_pc_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, trap, call, ret;
  logic [31:0] tgt;
  logic [31:0] pc, pc_nxt;
  logic        pc_valid, ras_empty, ras_full, misalign_err, ras_underflow;

  int total = 0;
  int bad   = 0;

  pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (tgt),
    .trap            (trap),
    .call            (call),
    .ret             (ret),
    .pc              (pc),
    .pc_nxt          (pc_nxt),
    .pc_valid        (pc_valid),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .misalign_err    (misalign_err),
    .ras_underflow   (ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, redirect, trap, call, ret;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_valid, e_empty, e_full, e_mis, e_und;
  } vec_t;

  vec_t vecs [23];

  // Reference model state
  logic [31:0] m_pc;
  logic        m_hold, m_valid, m_mis, m_und;
  logic [31:0] ras_q [$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // ctl = {stall, redirect, trap, call, ret}; flg = {valid, empty, full, misalign, underflow}
  function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] t,
                              input logic [31:0] e_pc, input logic [4:0] flg);
    vec_t v;
    {v.stall, v.redirect, v.trap, v.call, v.ret} = ctl;
    v.tgt  = t;
    v.e_pc = e_pc;
    {v.e_valid, v.e_empty, v.e_full, v.e_mis, v.e_und} = flg;
    return v;
  endfunction

  function automatic logic [31:0] m_next();
    logic adv;
    adv = !stall && !trap && !redirect;
    if (trap) return 32'h0000_0100;
    if (redirect) return {tgt[31:2], 2'b00};
    if (ret && adv && ras_q.size() > 0) return ras_q[ras_q.size()-1];
    if (stall) return m_pc;
    return m_pc + 32'd4;
  endfunction

  task automatic m_edge();
    logic [31:0] nxt;
    logic        adv;
    int          sz;
    nxt = m_next();
    adv = !stall && !trap && !redirect;
    sz  = ras_q.size();
    if (adv && ret && sz > 0) void'(ras_q.pop_back());
    if (adv && call) begin
      if (ras_q.size() == DEPTH) void'(ras_q.pop_front());
      ras_q.push_back(m_pc + 32'd4);
    end
    m_und   = adv && ret && (sz == 0);
    m_mis   = redirect && !trap && (tgt[1:0] != 2'b00);
    m_valid = m_hold ? 1'b1 : !(trap || redirect);
    m_hold  = 1'b0;
    m_pc    = nxt;
  endtask

  task automatic idle();
    stall = 1'b0; redirect = 1'b0; trap = 1'b0; call = 1'b0; ret = 1'b0; tgt = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(5'b00010, 32'h0,    32'h8004, 5'b10000);
    vecs[1]  = mk(5'b00010, 32'h0,    32'h8008, 5'b10000);
    vecs[2]  = mk(5'b00010, 32'h0,    32'h800C, 5'b10000);
    vecs[3]  = mk(5'b00010, 32'h0,    32'h8010, 5'b10100);
    vecs[4]  = mk(5'b00010, 32'h0,    32'h8014, 5'b10100);
    vecs[5]  = mk(5'b00001, 32'h0,    32'h8014, 5'b10000);
    vecs[6]  = mk(5'b00001, 32'h0,    32'h8010, 5'b10000);
    vecs[7]  = mk(5'b00001, 32'h0,    32'h800C, 5'b10000);
    vecs[8]  = mk(5'b00001, 32'h0,    32'h8008, 5'b11000);
    vecs[9]  = mk(5'b00001, 32'h0,    32'h800C, 5'b11001);
    vecs[10] = mk(5'b00000, 32'h0,    32'h8010, 5'b11000);
    vecs[11] = mk(5'b00010, 32'h0,    32'h8014, 5'b10000);
    vecs[12] = mk(5'b11000, 32'h1002, 32'h1000, 5'b00010);
    vecs[13] = mk(5'b00000, 32'h0,    32'h1004, 5'b10000);
    vecs[14] = mk(5'b00010, 32'h0,    32'h1008, 5'b10000);
    vecs[15] = mk(5'b01110, 32'h2000, 32'h0100, 5'b00000);
    vecs[16] = mk(5'b01000, 32'h3000, 32'h3000, 5'b00000);
    vecs[17] = mk(5'b00000, 32'h0,    32'h3004, 5'b10000);
    vecs[18] = mk(5'b00001, 32'h0,    32'h1008, 5'b10000);
    vecs[19] = mk(5'b00011, 32'h0,    32'h8014, 5'b10000);
    vecs[20] = mk(5'b00001, 32'h0,    32'h100C, 5'b11000);
    vecs[21] = mk(5'b10000, 32'h0,    32'h100C, 5'b11000);
    vecs[22] = mk(5'b10001, 32'h0,    32'h100C, 5'b11000);

    rst = 1'b0;
    idle();
    #10;
    chk("reset pc", pc, 32'h8000);
    chk("reset valid", {31'b0, pc_valid}, 32'd0);
    chk("reset empty", {31'b0, ras_empty}, 32'd1);
    chk("reset full", {31'b0, ras_full}, 32'd0);
    chk("reset misalign", {31'b0, misalign_err}, 32'd0);
    chk("reset underflow", {31'b0, ras_underflow}, 32'd0);
    #12;
    rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      stall = vecs[i].stall; redirect = vecs[i].redirect; trap = vecs[i].trap;
      call = vecs[i].call; ret = vecs[i].ret; tgt = vecs[i].tgt;
      #1;
      chk($sformatf("v%0d pc_nxt", i), pc_nxt, vecs[i].e_pc);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d flags", i),
          {27'b0, pc_valid, ras_empty, ras_full, misalign_err, ras_underflow},
          {27'b0, vecs[i].e_valid, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_mis, vecs[i].e_und});
    end

    // Wrap-around at the top of the address space
    idle(); redirect = 1'b1; tgt = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    chk("wrap setup pc", pc, 32'hFFFF_FFFC);
    idle();
    #1;
    chk("wrap pc_nxt", pc_nxt, 32'h0);
    @(posedge clk); #1;
    chk("wrap pc", pc, 32'h0);
    chk("wrap valid", {31'b0, pc_valid}, 32'd1);

    // Asynchronous reset in the middle of a FLUSH
    call = 1'b1;
    @(posedge clk); #1;
    chk("pre-reset empty", {31'b0, ras_empty}, 32'd0);
    idle(); redirect = 1'b1; tgt = 32'h0000_0200;
    @(posedge clk); #1;
    chk("flush pc", pc, 32'h200);
    chk("flush valid", {31'b0, pc_valid}, 32'd0);
    idle();
    #1 rst = 1'b0;
    #1;
    chk("async rst pc", pc, 32'h8000);
    chk("async rst empty", {31'b0, ras_empty}, 32'd1);
    chk("async rst valid", {31'b0, pc_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    m_pc = 32'h8000; m_hold = 1'b1; m_valid = 1'b0; m_mis = 1'b0; m_und = 1'b0;
    ras_q.delete();

    for (int c = 0; c < 600; c++) begin
      stall    = ($urandom_range(3) == 0);
      redirect = ($urandom_range(7) == 0);
      trap     = ($urandom_range(19) == 0);
      call     = ($urandom_range(3) == 0);
      ret      = ($urandom_range(3) == 0);
      tgt      = $urandom;
      if ($urandom_range(1) == 0) tgt[1:0] = 2'b00;
      #1;
      chk($sformatf("r%0d pc_nxt", c), pc_nxt, m_next());
      @(posedge clk);
      m_edge();
      #1;
      chk($sformatf("r%0d pc", c), pc, m_pc);
      chk($sformatf("r%0d flags", c),
          {27'b0, pc_valid, ras_empty, ras_full, misalign_err, ras_underflow},
          {27'b0, m_valid, (ras_q.size() == 0), (ras_q.size() == DEPTH), m_mis, m_und});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
